// File: rtl/v30mz_pkg.sv
// Shared v30mz bus encodings, BCU state type, request bundle and reset vector.
package v30mz_pkg;

    localparam logic [3:0] BUS_IDLE      = 4'hF;
    localparam logic [3:0] BUS_FETCH     = 4'b1001;
    localparam logic [3:0] BUS_MEM_READ  = 4'b1010;
    localparam logic [3:0] BUS_MEM_WRITE = 4'b1100;

    localparam logic [15:0] RESET_PS = 16'hFFFF;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DATA_LO,
        ST_DATA_HI
    } bcu_state_t;

    typedef struct packed {
        logic        write;
        logic        word;
        logic [15:0] seg;
        logic [15:0] offset;
        logic [15:0] wdata;
    } bcu_req_t;

endpackage

// File: rtl/bus_control_unit_physical_address.sv
// Segment:offset to 20-bit physical address, zero latency, no flow control; wraps past FFFFF.
module physical_address (
    input  logic [15:0] i_seg,
    input  logic [15:0] i_off,
    output logic [19:0] o_addr
);

    assign o_addr = {i_seg, 4'h0} + {4'h0, i_off};

endmodule

// File: rtl/bus_control_unit.sv
// v30mz bus control unit: prefetch vs EXU arbitration; push/rsp one cycle after readyb low.
// Waits on readyb indefinitely unless BCU_WAIT_TIMEOUT_EN adds a WAIT_LIMIT abort and bus_timeout.
module bus_control_unit
    import v30mz_pkg::*;
#(
    parameter int QUEUE_BYTES = 8
`ifdef BCU_WAIT_TIMEOUT_EN
    , parameter int WAIT_LIMIT = 8
`endif
) (
    input  logic                             clk,
    input  logic                             resetb,
    input  logic                             readyb,
    input  logic [15:0]                      data_in,
    output logic [19:0]                      address_out,
    output logic [15:0]                      data_out,
    output logic [1:0]                       byte_en,
    output logic [3:0]                       bus_status,
    input  logic [15:0]                      ps,
    input  logic [$clog2(QUEUE_BYTES+1)-1:0] queue_space,
    input  logic                             flush,
    input  logic [15:0]                      flush_pc,
    output logic                             push_queue,
    output logic [15:0]                      push_data,
    output logic                             push_two,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic                             req_word,
    input  logic [15:0]                      req_seg,
    input  logic [15:0]                      req_offset,
    input  logic [15:0]                      req_wdata,
    output logic                             rsp_valid,
`ifdef BCU_WAIT_TIMEOUT_EN
    output logic                             bus_timeout,
`endif
    output logic [15:0]                      rsp_rdata
);

    localparam int QW = $clog2(QUEUE_BYTES + 1);

    bcu_state_t  r_state;
    bcu_req_t    r_req;
    logic [15:0] r_pfp;
    logic        r_fetch_odd;
    logic        r_flush_pend;
    logic [7:0]  r_lo_byte;
    logic        r_push;

    logic [19:0]   w_fetch_addr;
    logic [19:0]   w_data_addr;
    logic [15:0]   w_data_seg;
    logic [15:0]   w_data_off;
    logic [QW-1:0] w_pend;
    logic [QW-1:0] w_space;
    logic          w_fetch_ok;
    logic          w_abort;
    logic [1:0]    w_req_ben;
    logic [15:0]   w_req_dout;
    logic [15:0]   w_rd_single;

    physical_address u_fetch_addr (
        .i_seg  (ps),
        .i_off  (r_pfp),
        .o_addr (w_fetch_addr)
    );

    // In IDLE the adder sees the incoming request; afterwards it sees offset+1 for the high byte.
    assign w_data_seg = (r_state == ST_IDLE) ? req_seg    : r_req.seg;
    assign w_data_off = (r_state == ST_IDLE) ? req_offset : r_req.offset + 16'd1;

    physical_address u_data_addr (
        .i_seg  (w_data_seg),
        .i_off  (w_data_off),
        .o_addr (w_data_addr)
    );

    // queue_space lags a push by a cycle, so bytes being pushed right now are not yet free.
    assign w_pend     = r_push ? (push_two ? QW'(2) : QW'(1)) : '0;
    assign w_space    = (queue_space >= w_pend) ? queue_space - w_pend : '0;
    assign w_fetch_ok = (w_space >= QW'(2)) || (r_pfp[0] && (w_space >= QW'(1)));

    assign req_ready  = (r_state == ST_IDLE) && req_valid && !flush;
    assign push_queue = r_push && !flush;

    assign w_req_ben  = req_offset[0] ? 2'b10 : (req_word ? 2'b11 : 2'b01);
    assign w_req_dout = req_offset[0] ? {req_wdata[7:0], 8'h00}
                      : (req_word ? req_wdata : {8'h00, req_wdata[7:0]});
    assign w_rd_single = r_req.word ? data_in
                       : (r_req.offset[0] ? {8'h00, data_in[15:8]} : {8'h00, data_in[7:0]});

`ifdef BCU_WAIT_TIMEOUT_EN
    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    logic [WCW-1:0] r_wait_cnt;
    logic           r_timeout;

    assign w_abort     = (r_state != ST_IDLE) && readyb && (r_wait_cnt == WCW'(WAIT_LIMIT - 1));
    assign bus_timeout = r_timeout;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == ST_IDLE || !readyb) begin
                r_wait_cnt <= '0;
            end else if (w_abort) begin
                r_wait_cnt <= '0;
                r_timeout  <= 1'b1;
            end else begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_pfp        <= RESET_PC;
            r_fetch_odd  <= 1'b0;
            r_flush_pend <= 1'b0;
            r_lo_byte    <= 8'h00;
            r_push       <= 1'b0;
            push_two     <= 1'b0;
            push_data    <= 16'h0000;
            address_out  <= {RESET_PS, 4'h0} + {4'h0, RESET_PC};
            bus_status   <= BUS_IDLE;
            byte_en      <= 2'b00;
            data_out     <= 16'h0000;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
        end else begin
            r_push    <= 1'b0;
            rsp_valid <= 1'b0;
            if (flush) begin
                r_pfp <= flush_pc;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!flush && req_valid) begin
                        r_req       <= '{write: req_write, word: req_word, seg: req_seg,
                                         offset: req_offset, wdata: req_wdata};
                        r_state     <= ST_DATA_LO;
                        address_out <= w_data_addr;
                        bus_status  <= req_write ? BUS_MEM_WRITE : BUS_MEM_READ;
                        byte_en     <= w_req_ben;
                        data_out    <= w_req_dout;
                    end else if (!flush && w_fetch_ok) begin
                        r_state      <= ST_FETCH;
                        r_fetch_odd  <= r_pfp[0];
                        r_flush_pend <= 1'b0;
                        address_out  <= w_fetch_addr;
                        bus_status   <= BUS_FETCH;
                        byte_en      <= r_pfp[0] ? 2'b10 : 2'b11;
                    end
                end

                ST_FETCH: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (!readyb || w_abort) begin
                        r_state    <= ST_IDLE;
                        bus_status <= BUS_IDLE;
                        byte_en    <= 2'b00;
                    end
                    // A flush during the fetch lets the cycle finish but drops its bytes.
                    if (!readyb) begin
                        push_two  <= !r_fetch_odd;
                        push_data <= r_fetch_odd ? {8'h00, data_in[15:8]} : data_in;
                        if (!flush && !r_flush_pend) begin
                            r_push <= 1'b1;
                            r_pfp  <= r_pfp + (r_fetch_odd ? 16'd1 : 16'd2);
                        end
                    end
                end

                ST_DATA_LO: begin
                    if (!readyb && r_req.word && r_req.offset[0]) begin
                        r_lo_byte   <= data_in[15:8];
                        r_state     <= ST_DATA_HI;
                        address_out <= w_data_addr;
                        byte_en     <= 2'b01;
                        data_out    <= {8'h00, r_req.wdata[15:8]};
                    end else if (!readyb || w_abort) begin
                        r_state    <= ST_IDLE;
                        bus_status <= BUS_IDLE;
                        byte_en    <= 2'b00;
                        rsp_valid  <= 1'b1;
                        if (!r_req.write) begin
                            rsp_rdata <= !readyb ? w_rd_single : 16'hFFFF;
                        end
                    end
                end

                ST_DATA_HI: begin
                    if (!readyb || w_abort) begin
                        r_state    <= ST_IDLE;
                        bus_status <= BUS_IDLE;
                        byte_en    <= 2'b00;
                        rsp_valid  <= 1'b1;
                        if (!r_req.write) begin
                            rsp_rdata <= !readyb ? {data_in[7:0], r_lo_byte} : 16'hFFFF;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_control_unit.sv
// Directed bench for bus_control_unit: prefetch, flush, odd fetch, split data cycles, reset.
module tb_bus_control_unit;

    logic        clk = 1'b0;
    logic        resetb, readyb, flush, req_valid, req_write, req_word;
    logic [15:0] data_in, ps, flush_pc, req_seg, req_offset, req_wdata;
    logic [3:0]  queue_space;
    logic [19:0] address_out;
    logic [15:0] data_out, push_data, rsp_rdata;
    logic [1:0]  byte_en;
    logic [3:0]  bus_status;
    logic        push_queue, push_two, req_ready, rsp_valid;
`ifdef BCU_WAIT_TIMEOUT_EN
    logic        bus_timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_control_unit dut (
        .clk         (clk),
        .resetb      (resetb),
        .readyb      (readyb),
        .data_in     (data_in),
        .address_out (address_out),
        .data_out    (data_out),
        .byte_en     (byte_en),
        .bus_status  (bus_status),
        .ps          (ps),
        .queue_space (queue_space),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .push_queue  (push_queue),
        .push_data   (push_data),
        .push_two    (push_two),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_word    (req_word),
        .req_seg     (req_seg),
        .req_offset  (req_offset),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
`ifdef BCU_WAIT_TIMEOUT_EN
        .bus_timeout (bus_timeout),
`endif
        .rsp_rdata   (rsp_rdata)
    );

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_status == 4'b1001) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Presents a request, completing any fetch in the way, and returns in the first data-cycle.
    task automatic issue_req(input bit w, input bit wd, input logic [15:0] seg, input logic [15:0] off,
                             input logic [15:0] wdat, output int waited, output bit ok);
        req_valid = 1'b1; req_write = w; req_word = wd;
        req_seg = seg; req_offset = off; req_wdata = wdat;
        ok = 1'b0; waited = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            readyb = 1'b0;
            waited++;
            @(negedge clk);
        end
        readyb = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        resetb = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (address_out !== 20'hFFFF0) begin n_fail++; $display("FAIL reset_addr got %h exp FFFF0", address_out); end
        n_checks++; if (bus_status !== 4'hF) begin n_fail++; $display("FAIL reset_status got %h exp F", bus_status); end
        n_checks++; if (byte_en !== 2'b00 || data_out !== 16'h0) begin n_fail++; $display("FAIL reset_ben_dout got %b/%h exp 00/0000", byte_en, data_out); end
        n_checks++; if ({push_queue, push_two, rsp_valid, req_ready} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes got %b exp 0000", {push_queue, push_two, rsp_valid, req_ready}); end
        resetb = 1'b1;
    endtask

    task automatic test_prefetch;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            wait_fetch(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL pf_wait%0d got no fetch exp fetch", i); end
            n_checks++; if (address_out !== 20'hFFFF0 + 20'(2 * i)) begin n_fail++; $display("FAIL pf_addr%0d got %h exp %h", i, address_out, 20'hFFFF0 + 20'(2 * i)); end
            n_checks++; if (byte_en !== 2'b11 || push_queue !== 1'b0) begin n_fail++; $display("FAIL pf_ben%0d got %b/%b exp 11/0", i, byte_en, push_queue); end
            data_in = 16'hA0B0 + 16'(i);
            readyb  = 1'b0;
            @(negedge clk);
            readyb = 1'b1;
            n_checks++; if (push_queue !== 1'b1 || push_two !== 1'b1) begin n_fail++; $display("FAIL pf_push%0d got %b%b exp 11", i, push_queue, push_two); end
            n_checks++; if (push_data !== 16'hA0B0 + 16'(i)) begin n_fail++; $display("FAIL pf_data%0d got %h exp %h", i, push_data, 16'hA0B0 + 16'(i)); end
            n_checks++; if (bus_status !== 4'hF) begin n_fail++; $display("FAIL pf_idle%0d got %h exp F", i, bus_status); end
        end
    endtask

    task automatic test_flush;
        bit ok;
        wait_fetch(ok);
        n_checks++; if (!ok || address_out !== 20'hFFFF6) begin n_fail++; $display("FAIL fl_pre got %h exp FFFF6", address_out); end
        flush = 1'b1; flush_pc = 16'h0003;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (bus_status !== 4'b1001 || address_out !== 20'hFFFF6) begin n_fail++; $display("FAIL fl_hold got %h/%h exp 9/FFFF6", bus_status, address_out); end
        data_in = 16'h1111; readyb = 1'b0;
        @(negedge clk);
        readyb = 1'b1;
        n_checks++; if (push_queue !== 1'b0) begin n_fail++; $display("FAIL fl_nopush got %b exp 0", push_queue); end
        n_checks++; if (bus_status !== 4'hF) begin n_fail++; $display("FAIL fl_idle got %h exp F", bus_status); end
    endtask

    task automatic test_odd_prefetch;
        bit ok;
        wait_fetch(ok);
        n_checks++; if (!ok || address_out !== 20'hFFFF3) begin n_fail++; $display("FAIL odd_addr got %h exp FFFF3", address_out); end
        n_checks++; if (byte_en !== 2'b10) begin n_fail++; $display("FAIL odd_ben got %b exp 10", byte_en); end
        data_in = 16'h5AC3; readyb = 1'b0;
        @(negedge clk);
        readyb = 1'b1;
        n_checks++; if (push_queue !== 1'b1 || push_two !== 1'b0) begin n_fail++; $display("FAIL odd_push got %b%b exp 10", push_queue, push_two); end
        n_checks++; if (push_data[7:0] !== 8'h5A) begin n_fail++; $display("FAIL odd_data got %h exp 5A", push_data[7:0]); end
        wait_fetch(ok);
        n_checks++; if (!ok || address_out !== 20'hFFFF4 || byte_en !== 2'b11) begin n_fail++; $display("FAIL odd_next got %h/%b exp FFFF4/11", address_out, byte_en); end
        data_in = 16'h2222; readyb = 1'b0;
        @(negedge clk);
        readyb = 1'b1;
    endtask

    task automatic test_word_read;
        bit ok; int waited;
        // Prefetch is eligible here (space 8, idle), so the request must win immediately.
        issue_req(1'b0, 1'b1, 16'h1000, 16'h0011, 16'h0000, waited, ok);
        n_checks++; if (!ok || waited != 0) begin n_fail++; $display("FAIL wr_prio got waited %0d exp 0", waited); end
        n_checks++; if (bus_status !== 4'b1010 || address_out !== 20'h10011 || byte_en !== 2'b10) begin n_fail++; $display("FAIL wr_lo got %h/%h/%b exp A/10011/10", bus_status, address_out, byte_en); end
        data_in = 16'hCD00; readyb = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_status !== 4'b1010 || address_out !== 20'h10012 || byte_en !== 2'b01) begin n_fail++; $display("FAIL wr_hi got %h/%h/%b exp A/10012/01", bus_status, address_out, byte_en); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_early got %b exp 0", rsp_valid); end
        data_in = 16'h00AB;
        @(negedge clk);
        readyb = 1'b1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hABCD) begin n_fail++; $display("FAIL wr_rsp got %b/%h exp 1/ABCD", rsp_valid, rsp_rdata); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'hABCD) begin n_fail++; $display("FAIL wr_hold got %b/%h exp 0/ABCD", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_write_wrap;
        bit ok; int waited;
        issue_req(1'b1, 1'b1, 16'h2000, 16'hFFFF, 16'h1234, waited, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ww_acc got no req_ready exp accept"); end
        n_checks++; if (bus_status !== 4'b1100 || address_out !== 20'h2FFFF || byte_en !== 2'b10 || data_out[15:8] !== 8'h34) begin n_fail++; $display("FAIL ww_lo got %h/%h/%b/%h exp C/2FFFF/10/34xx", bus_status, address_out, byte_en, data_out); end
        readyb = 1'b0;
        @(negedge clk);
        n_checks++; if (address_out !== 20'h20000 || byte_en !== 2'b01 || data_out[7:0] !== 8'h12) begin n_fail++; $display("FAIL ww_hi got %h/%b/%h exp 20000/01/xx12", address_out, byte_en, data_out); end
        @(negedge clk);
        readyb = 1'b1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hABCD) begin n_fail++; $display("FAIL ww_rsp got %b/%h exp 1/ABCD", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_byte_access;
        bit ok; int waited;
        issue_req(1'b0, 1'b0, 16'h1000, 16'h0005, 16'h0000, waited, ok);
        n_checks++; if (!ok || address_out !== 20'h10005 || byte_en !== 2'b10) begin n_fail++; $display("FAIL br_odd got %h/%b exp 10005/10", address_out, byte_en); end
        data_in = 16'h9F11; readyb = 1'b0;
        @(negedge clk);
        readyb = 1'b1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h009F) begin n_fail++; $display("FAIL br_rsp got %b/%h exp 1/009F", rsp_valid, rsp_rdata); end
        issue_req(1'b1, 1'b0, 16'h1000, 16'h0004, 16'h55AA, waited, ok);
        n_checks++; if (!ok || byte_en !== 2'b01 || data_out[7:0] !== 8'hAA || bus_status !== 4'b1100) begin n_fail++; $display("FAIL bw_even got %b/%h/%h exp 01/xxAA/C", byte_en, data_out, bus_status); end
        readyb = 1'b0;
        @(negedge clk);
        readyb = 1'b1;
        n_checks++; if (rsp_valid !== 1'b1 || bus_status !== 4'hF) begin n_fail++; $display("FAIL bw_rsp got %b/%h exp 1/F", rsp_valid, bus_status); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        wait_fetch(ok);
        resetb = 1'b0;
        #1;
        n_checks++; if (!ok || bus_status !== 4'hF || address_out !== 20'hFFFF0) begin n_fail++; $display("FAIL rm_async got %h/%h exp F/FFFF0", bus_status, address_out); end
        @(negedge clk);
        n_checks++; if (push_queue !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_quiet got %b%b exp 00", push_queue, rsp_valid); end
        resetb = 1'b1;
        wait_fetch(ok);
        n_checks++; if (!ok || address_out !== 20'hFFFF0) begin n_fail++; $display("FAIL rm_restart got %h exp FFFF0", address_out); end
    endtask

`ifdef BCU_WAIT_TIMEOUT_EN
    task automatic test_timeout;
        bit ok; int waited; int n;
        issue_req(1'b0, 1'b1, 16'h1000, 16'h0000, 16'h0000, waited, ok);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus_timeout === 1'b1) begin
                n = k;
                break;
            end
        end
        n_checks++; if (!ok || n != 8) begin n_fail++; $display("FAIL to_cycle got %0d exp 8", n); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL to_rsp got %b/%h exp 1/FFFF", rsp_valid, rsp_rdata); end
    endtask
`endif

    initial begin
        resetb = 1'b0; readyb = 1'b1; data_in = 16'h0; ps = 16'hFFFF; queue_space = 4'd8;
        flush = 1'b0; flush_pc = 16'h0; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
        req_seg = 16'h0; req_offset = 16'h0; req_wdata = 16'h0;
        test_reset;
        test_prefetch;
        test_flush;
        test_odd_prefetch;
        test_word_read;
        test_write_wrap;
        test_byte_access;
        test_reset_mid;
`ifdef BCU_WAIT_TIMEOUT_EN
        test_timeout;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
